// File: rtl/ecc_pkg.sv
// Shared widths, FSM state encoding and codeword layout for the ECC scrubber.
package ecc_pkg;

  localparam int DATA_W = 32;
  localparam int ECC_W  = 7;
  localparam int CW_W   = DATA_W + ECC_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_DONE
  } scrub_state_e;

  // Check bits sit above the data so the packed struct matches {ecc, data}.
  typedef struct packed {
    logic [ECC_W-1:0]  ecc;
    logic [DATA_W-1:0] data;
  } codeword_t;

  function automatic codeword_t make_cw(input logic [ECC_W-1:0] ecc, input logic [DATA_W-1:0] data);
    codeword_t cw;
    cw.ecc  = ecc;
    cw.data = data;
    return cw;
  endfunction

endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment wins.
module ecc_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background SECDED scrubber: paced reads over the array, write-back of
// corrected words, logging of uncorrectable ones.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for scrub_start
// S_GAP     | pacing delay of INTERVAL cycles before the next read
// S_RD_REQ  | rd_req held for the current address until rd_gnt
// S_RD_WAIT | read granted, waiting for the decoder result
// S_WR_REQ  | write-back of the corrected codeword held until wr_gnt
// S_DONE    | one-cycle pass end (done pulse), back to S_IDLE
module ecc_scrub_ctrl
  import ecc_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int INTERVAL = 16,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              scrub_start,
  input  logic              scrub_abort,
  input  logic              clr_status,
  output logic              rd_req,
  output logic [AW-1:0]     rd_addr,
  input  logic              rd_gnt,
  input  logic              dec_valid,
  input  logic [DATA_W-1:0] dec_dout,
  input  logic [ECC_W-1:0]  dec_ecc_out,
  input  logic              dec_single_ecc_error,
  input  logic              dec_double_ecc_error,
  output logic              wr_req,
  output logic [AW-1:0]     wr_addr,
  output logic [CW_W-1:0]   wr_data,
  input  logic              wr_gnt,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count,
  output logic              ded_first_valid,
  output logic [AW-1:0]     ded_first_addr,
  output logic              irq_ded
);

  localparam int GAP_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (INTERVAL > 0) ? GAP_W'(INTERVAL - 1) : '0;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  scrub_state_e     state;
  logic [AW-1:0]    addr;
  logic [GAP_W-1:0] gap_cnt;
  codeword_t        wr_cw;

  logic dec_take;
  logic sec_inc;
  logic ded_inc;
  logic advance;
  logic finish_pass;

  // Double error takes priority over single when the decoder flags both.
  assign dec_take    = (state == S_RD_WAIT) && dec_valid;
  assign ded_inc     = dec_take && dec_double_ecc_error;
  assign sec_inc     = dec_take && dec_single_ecc_error && !dec_double_ecc_error;
  assign advance     = (dec_take && !sec_inc) || ((state == S_WR_REQ) && wr_gnt);
  assign finish_pass = (addr == LAST_ADDR) || scrub_abort;

  assign rd_addr = addr;
  assign wr_data = wr_cw;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state           <= S_IDLE;
      addr            <= '0;
      gap_cnt         <= '0;
      rd_req          <= 1'b0;
      wr_req          <= 1'b0;
      wr_addr         <= '0;
      wr_cw           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      ded_first_valid <= 1'b0;
      ded_first_addr  <= '0;
      irq_ded         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (scrub_start) begin
            addr   <= '0;
            busy   <= 1'b1;
            rd_req <= 1'b1;
            state  <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (rd_gnt) begin
            rd_req <= 1'b0;
            state  <= S_RD_WAIT;
          end else if (scrub_abort) begin
            rd_req <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_RD_WAIT: begin
          if (ded_inc) begin
            if (!ded_first_valid) begin
              ded_first_valid <= 1'b1;
              ded_first_addr  <= addr;
            end
            irq_ded <= 1'b1;
          end else if (sec_inc) begin
            wr_req  <= 1'b1;
            wr_addr <= addr;
            wr_cw   <= make_cw(dec_ecc_out, dec_dout);
            state   <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (wr_gnt) wr_req <= 1'b0;
        end
        S_GAP: begin
          if (scrub_abort) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (gap_cnt == '0) begin
            rd_req <= 1'b1;
            state  <= S_RD_REQ;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Leaving a word: either end the pass or step to the next address.
      if (advance) begin
        if (finish_pass) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end else begin
          addr <= addr + AW'(1);
          if (INTERVAL > 0) begin
            gap_cnt <= GAP_LOAD;
            state   <= S_GAP;
          end else begin
            rd_req <= 1'b1;
            state  <= S_RD_REQ;
          end
        end
      end

      if (clr_status) begin
        ded_first_valid <= 1'b0;
        ded_first_addr  <= '0;
        irq_ded         <= 1'b0;
      end
    end
  end

  ecc_sat_counter #(.W(CNT_W)) u_sec_cnt (
    .clk   (clk),
    .rst_l (rst_l),
    .inc   (sec_inc),
    .clr   (clr_status),
    .count (sec_count)
  );

  ecc_sat_counter #(.W(CNT_W)) u_ded_cnt (
    .clk   (clk),
    .rst_l (rst_l),
    .inc   (ded_inc),
    .clr   (clr_status),
    .count (ded_count)
  );

endmodule

// File: doc/ecc_scrub_ctrl.md
Name: ecc_scrub_ctrl

Overview:
Background scrubber for a SECDED-protected memory of 39-bit codewords (32 data + 7 check bits). Walks the address space one word at a time and issues reads. It consumes the outputs of the downstream SECDED decoder (corrected data, corrected check bits, single/double error flags). On a single error it writes back the corrected codeword; on a double error it logs the address. It is the consumer stage directly after the decoder and the only writer of repaired words.

Parameters:
DEPTH, 1024, number of codewords scrubbed per pass; addresses 0..DEPTH-1
AW, $clog2(DEPTH), address width
INTERVAL, 16, idle cycles between consecutive reads (pacing); 0 = back-to-back
CNT_W, 16, width of saturating error counters

Ports:
clk  in  1  clock
rst_l  in  1  async active-low reset
scrub_start  in  1  pulse; begin a pass at address 0 (ignored while busy)
scrub_abort  in  1  level; stop the pass at the next safe point
clr_status  in  1  pulse; clear counters, DED log and irq_ded
rd_req  out  1  read request; held until rd_gnt
rd_addr  out  AW  read address; stable while rd_req
rd_gnt  in  1  read accepted in the cycle both rd_req and rd_gnt are high
dec_valid  in  1  decoder result valid (1 per granted read, any latency ≥1)
dec_dout  in  32  corrected data from decoder
dec_ecc_out  in  7  corrected check bits from decoder
dec_single_ecc_error  in  1  single error corrected
dec_double_ecc_error  in  1  uncorrectable double error
wr_req  out  1  write-back request; held until wr_gnt
wr_addr  out  AW  write-back address
wr_data  out  39  {dec_ecc_out, dec_dout} captured at dec_valid
wr_gnt  in  1  write accepted when wr_req && wr_gnt
busy  out  1  pass in progress
done  out  1  1-cycle pulse at pass end (normal or aborted)
sec_count  out  CNT_W  saturating single-error count
ded_count  out  CNT_W  saturating double-error count
ded_first_valid  out  1  ded_first_addr holds a logged address
ded_first_addr  out  AW  address of the first double error since the last clear
irq_ded  out  1  sticky; set on any double error

Behaviour:
- Async reset (rst_l low): state IDLE; every output 0 and all counters/registers 0. Reset mid-pass drops all outstanding requests immediately.
- FSM states: IDLE, GAP, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE: scrub_start → addr=0, busy=1, go to RD_REQ. scrub_start is ignored outside IDLE.
- RD_REQ: rd_req=1, rd_addr=addr. On rd_gnt go to RD_WAIT. If scrub_abort is high before the grant, go to DONE without a read.
- RD_WAIT: wait for dec_valid. A granted read always completes, even under abort.
  - If double flag is set (priority over single, including when both flags are high): ded_count+1. If !ded_first_valid, capture addr and set ded_first_valid. irq_ded=1. No write-back. Go to NEXT.
  - Else if single flag is set: sec_count+1; latch wr_addr=addr and wr_data={dec_ecc_out,dec_dout}; go to WR_REQ.
  - Else go to NEXT.
- WR_REQ: wr_req=1 until wr_gnt. Cannot be aborted; abort is honoured after the grant. Then go to NEXT.
- NEXT (transitional, evaluated in the same cycle as the exit above):
  - addr==DEPTH-1 or scrub_abort → DONE.
  - Otherwise addr+1, then GAP if INTERVAL>0, else RD_REQ.
- GAP: counts INTERVAL cycles, then goes to RD_REQ. scrub_abort during GAP → DONE.
- DONE: done=1 for one cycle, busy=0, go to IDLE. The next pass restarts at 0; there is no wrap-resume.
- Counters saturate at 2^CNT_W-1.
- clr_status coincident with an increment: clear wins (result 0).
- clr_status does not affect the FSM.
- rd_req and wr_req are never high simultaneously.
- dec_valid outside RD_WAIT is ignored.

Decomposition:
- Shared package ecc_pkg: DATA_W=32, ECC_W=7, CW_W=39, scrub_state_e enum, codeword typedef (struct {ecc[6:0], data[31:0]}).
- One sub-module: ecc_sat_counter (parameter W; inc and clr inputs, clr priority, saturating), instantiated twice.

Test Plan:
- DEPTH=4, INTERVAL=0, all results clean → 4 reads at addresses 0,1,2,3; no wr_req; done pulses once; sec_count=0; busy low afterwards.
- Addr 2 returns single=1, dout=0xDEADBEEF, ecc_out=0x5A → wr_req with wr_addr=2, wr_data=0x5A_DEADBEEF; sec_count=1; read of addr 3 only after wr_gnt.
- Addr 1 and addr 3 return double=1 → ded_count=2, ded_first_addr=1, irq_ded=1, no writes; clr_status → all zeroed.
- single and double both high at addr 0 → treated as double: ded_count=1, sec_count=0, no write-back.
- scrub_abort asserted during RD_WAIT of addr 1 with single error; wr_gnt delayed 5 cycles → write to addr 1 completes, then done; no read of addr 2.
- CNT_W=2, 5 single errors → sec_count stays at 3. rst_l low while wr_req is high → wr_req=0 immediately, all outputs 0.
